// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, default sizes and requester id.
package mult_pkg;

    localparam int WIDTH_DEF   = 5;
    localparam int TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID0 = 1'b0;
    localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational winner selection between two requesters; ptr breaks ties.
module mult_arb_pick
    import mult_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t ptr,
    output logic    vld,
    output req_id_t win
);

    always_comb begin
        vld = req0 | req1;
        win = REQ_ID0;
        if (req0 && req1) begin
            win = ptr;
        end else if (req1) begin
            win = REQ_ID1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared signed multiplier with timeout.
// Define MULT_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic                      req1,
    input  logic signed [WIDTH-1:0]   a0,
    input  logic signed [WIDTH-1:0]   b0,
    input  logic signed [WIDTH-1:0]   a1,
    input  logic signed [WIDTH-1:0]   b1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      m_start,
    output logic signed [WIDTH-1:0]   m_x,
    output logic signed [WIDTH-1:0]   m_y,
    input  logic                      m_done,
    input  logic signed [2*WIDTH-1:0] m_product,
    output logic signed [2*WIDTH-1:0] res,
    output logic                      res_valid,
    output logic                      res_id,
    output logic                      res_err,
    output logic                      busy
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t                    state_q;
    logic                      m_start_q;
    logic signed [WIDTH-1:0]   m_x_q;
    logic signed [WIDTH-1:0]   m_y_q;
    logic signed [2*WIDTH-1:0] res_q;
    logic                      res_valid_q;
    req_id_t                   res_id_q;
    logic                      res_err_q;
    logic                      busy_q;
    req_id_t                   owner_q;
    logic [CNT_W-1:0]          cnt_q;

    logic    vld_d;
    req_id_t win_d;
    req_id_t ptr_d;
    logic    grant_d;

`ifdef MULT_ARB_RR_EN
    req_id_t ptr_q;
    assign ptr_d = ptr_q;
`else
    assign ptr_d = REQ_ID0;
`endif

    mult_arb_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr_d),
        .vld  (vld_d),
        .win  (win_d)
    );

    // Grants are only meaningful in the IDLE cycle whose edge latches the operands.
    assign grant_d = (state_q == ST_IDLE) && !rst && vld_d;
    assign gnt0    = grant_d && (win_d == REQ_ID0);
    assign gnt1    = grant_d && (win_d == REQ_ID1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_start_q   <= 1'b0;
            m_x_q       <= '0;
            m_y_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= REQ_ID0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= REQ_ID0;
            cnt_q       <= '0;
`ifdef MULT_ARB_RR_EN
            ptr_q       <= REQ_ID0;
`endif
        end else begin
            m_start_q   <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (vld_d) begin
                        m_x_q     <= (win_d == REQ_ID1) ? a1 : a0;
                        m_y_q     <= (win_d == REQ_ID1) ? b1 : b0;
                        owner_q   <= win_d;
`ifdef MULT_ARB_RR_EN
                        ptr_q     <= ~win_d;
`endif
                        m_start_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        res_q       <= m_product;
                        res_err_q   <= 1'b0;
                        res_id_q    <= owner_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        res_q       <= '0;
                        res_err_q   <= 1'b1;
                        res_id_q    <= owner_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_start   = m_start_q;
    assign m_x       = m_x_q;
    assign m_y       = m_y_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter; tie-break expectations follow MULT_ARB_RR_EN.
module tb_mult_arbiter;

    localparam int W  = 5;
    localparam int TO = 40;
`ifdef MULT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req0 = 1'b0, req1 = 1'b0;
    logic signed [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic                  gnt0, gnt1, m_start;
    logic signed [W-1:0]   m_x, m_y;
    logic                  m_done = 1'b0;
    logic signed [2*W-1:0] m_product = '0;
    logic signed [2*W-1:0] res;
    logic                  res_valid, res_id, res_err, busy;

    int nchk  = 0;
    int nfail = 0;

    mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .m_start   (m_start),
        .m_x       (m_x),
        .m_y       (m_y),
        .m_done    (m_done),
        .m_product (m_product),
        .res       (res),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one transaction from an IDLE cycle with the request already driven.
    task automatic do_op(input string tag, input logic id, input logic signed [W-1:0] x,
                         input logic signed [W-1:0] y, input logic signed [2*W-1:0] p,
                         input logic drop);
        #1;
        chk({tag, "_gnt0"}, 16'(gnt0), 16'(id == 1'b0));
        chk({tag, "_gnt1"}, 16'(gnt1), 16'(id == 1'b1));
        tick();
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        #1;
        chk({tag, "_mstart"}, 16'(m_start), 16'(1'b1));
        chk({tag, "_mx"}, 16'(m_x), 16'(x));
        chk({tag, "_my"}, 16'(m_y), 16'(y));
        chk({tag, "_nognt"}, 16'(gnt0 | gnt1), 16'(1'b0));
        tick();
        m_done    = 1'b1;
        m_product = p;
        tick();
        m_done = 1'b0;
        #1;
        chk({tag, "_rv"}, 16'(res_valid), 16'(1'b1));
        chk({tag, "_res"}, 16'(res), 16'(p));
        chk({tag, "_rid"}, 16'(res_id), 16'(id));
        chk({tag, "_rerr"}, 16'(res_err), 16'(1'b0));
        tick();
    endtask

    initial begin
        logic id_e;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_busy", 16'(busy), 16'(1'b0));
        chk("rst_mstart", 16'(m_start), 16'(1'b0));
        chk("rst_rv", 16'(res_valid), 16'(1'b0));
        chk("rst_res", 16'(res), 16'(0));
        chk("rst_mx", 16'(m_x), 16'(0));
        chk("rst_gnt", 16'({gnt0, gnt1}), 16'(0));
        rst = 1'b0;
        tick();

        // Basic signed product for requester 0
        req0 = 1'b1; a0 = 5'sd7; b0 = -5'sd3;
        do_op("t1", 1'b0, 5'sd7, -5'sd3, -10'sd21, 1'b1);
        #1;
        chk("t1_rv_low", 16'(res_valid), 16'(1'b0));
        chk("t1_busy_low", 16'(busy), 16'(1'b0));
        chk("t1_res_hold", 16'(res), 16'(-10'sd21));

        // Both requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a0 = 5'sd3; b0 = 5'sd2; a1 = -5'sd4; b1 = 5'sd5;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_e = RR ? 1'(i % 2) : 1'b0;
            if (id_e) do_op($sformatf("t2_%0d", i), 1'b1, -5'sd4, 5'sd5, -10'sd20, 1'b0);
            else      do_op($sformatf("t2_%0d", i), 1'b0, 5'sd3, 5'sd2, 10'sd6, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Timeout: m_done never arrives
        req0 = 1'b1; a0 = -5'sd16; b0 = -5'sd16;
        #1;
        chk("t3_gnt0", 16'(gnt0), 16'(1'b1));
        tick();
        req0 = 1'b0;
        tick();
        repeat (TO) tick();
        #1;
        chk("t3_rv_early", 16'(res_valid), 16'(1'b0));
        chk("t3_busy_wait", 16'(busy), 16'(1'b1));
        tick();
        #1;
        chk("t3_rv", 16'(res_valid), 16'(1'b1));
        chk("t3_res", 16'(res), 16'(0));
        chk("t3_rerr", 16'(res_err), 16'(1'b1));
        chk("t3_rid", 16'(res_id), 16'(1'b0));
        tick();
        #1;
        chk("t3_busy_fall", 16'(busy), 16'(1'b0));
        chk("t3_rv_low", 16'(res_valid), 16'(1'b0));

        // Reset during WAIT
        req1 = 1'b1; a1 = 5'sd2; b1 = 5'sd3;
        #1;
        chk("t4_gnt1", 16'(gnt1), 16'(1'b1));
        tick();
        req1 = 1'b0;
        #1;
        chk("t4_mx", 16'(m_x), 16'(5'sd2));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_done = 1'b1; m_product = 10'sd99;
        #1;
        chk("t4_busy", 16'(busy), 16'(1'b0));
        chk("t4_mstart", 16'(m_start), 16'(1'b0));
        chk("t4_mxy", 16'({m_x, m_y}), 16'(0));
        chk("t4_res", 16'(res), 16'(0));
        chk("t4_rv", 16'(res_valid), 16'(1'b0));
        chk("t4_rerr", 16'(res_err), 16'(1'b0));
        tick();
        #1;
        chk("t4_ignore_rv", 16'(res_valid), 16'(1'b0));
        chk("t4_ignore_busy", 16'(busy), 16'(1'b0));
        m_done = 1'b0;
        req0 = 1'b1; a0 = -5'sd5; b0 = 5'sd4;
        do_op("t4_next", 1'b0, -5'sd5, 5'sd4, -10'sd20, 1'b1);

        // m_done held two cycles, req1 raised during WAIT
        req0 = 1'b1; a0 = -5'sd7; b0 = -5'sd8;
        #1;
        chk("t5_gnt0", 16'(gnt0), 16'(1'b1));
        tick();
        req0 = 1'b0;
        tick();
        m_done = 1'b1; m_product = 10'sd56;
        req1 = 1'b1; a1 = 5'sd15; b1 = 5'sd15;
        #1;
        chk("t5_nognt1_wait", 16'(gnt1), 16'(1'b0));
        tick();
        #1;
        chk("t5_rv", 16'(res_valid), 16'(1'b1));
        chk("t5_res", 16'(res), 16'(10'sd56));
        chk("t5_nognt1_resp", 16'(gnt1), 16'(1'b0));
        tick();
        m_done = 1'b0;
        #1;
        chk("t5_single_rv", 16'(res_valid), 16'(1'b0));
        chk("t5_gnt1", 16'(gnt1), 16'(1'b1));
        chk("t5_gnt0", 16'(gnt0), 16'(1'b0));
        tick();
        req1 = 1'b0;
        #1;
        chk("t5_mx", 16'(m_x), 16'(5'sd15));
        tick();
        m_done = 1'b1; m_product = 10'sd225;
        tick();
        m_done = 1'b0;
        #1;
        chk("t5_rv2", 16'(res_valid), 16'(1'b1));
        chk("t5_res2", 16'(res), 16'(10'sd225));
        chk("t5_rid2", 16'(res_id), 16'(1'b1));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
